// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : 8N1-style UART receive stage, mid-bit sampling on a 16x tick
//             enable, with valid / frame-error strobes and break lockout.
//  Revision : 1.0  initial release
// ============================================================================
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxTick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataValid,
    output logic                 frameError,
    output logic                 busy
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    // Last tick index of the half-bit (start centre) and full-bit windows
    localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_FULL = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        c_IDLE  = 3'd0,
        c_START = 3'd1,
        c_DATA  = 3'd2,
        c_STOP  = 3'd3,
        c_BREAK = 3'd4
    } state_t;

    logic                 r_rxMeta;
    logic                 r_rxS;
    state_t               r_state;
    logic [c_TICK_W-1:0]  r_tickCnt;
    logic [c_BIT_W-1:0]   r_bitCnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_dataOut;
    logic                 r_dataValid;
    logic                 r_frameError;

    state_t               w_stateNext;
    logic [c_TICK_W-1:0]  w_tickNext;
    logic [c_BIT_W-1:0]   w_bitNext;
    logic [DATA_BITS-1:0] w_shiftNext;
    logic [DATA_BITS-1:0] w_dataNext;
    logic                 w_validNext;
    logic                 w_errorNext;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxS    <= r_rxMeta;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_tickNext  = r_tickCnt;
        w_bitNext   = r_bitCnt;
        w_shiftNext = r_shift;
        w_dataNext  = r_dataOut;
        w_validNext = 1'b0;
        w_errorNext = 1'b0;

        if (rxTick) begin
            case (r_state)
                c_IDLE: begin
                    if (!r_rxS) begin
                        w_stateNext = c_START;
                        w_tickNext  = '0;
                    end
                end

                c_START: begin
                    if (r_tickCnt == c_TICK_HALF) begin
                        w_tickNext = '0;
                        if (!r_rxS) begin
                            w_stateNext = c_DATA;
                            w_bitNext   = '0;
                        end else begin
                            w_stateNext = c_IDLE;
                        end
                    end else begin
                        w_tickNext = r_tickCnt + c_TICK_W'(1);
                    end
                end

                c_DATA: begin
                    if (r_tickCnt == c_TICK_FULL) begin
                        w_tickNext  = '0;
                        w_shiftNext = {r_rxS, r_shift[DATA_BITS-1:1]};
                        w_bitNext   = r_bitCnt + c_BIT_W'(1);
                        if (r_bitCnt == c_BIT_LAST) begin
                            w_stateNext = c_STOP;
                        end
                    end else begin
                        w_tickNext = r_tickCnt + c_TICK_W'(1);
                    end
                end

                c_STOP: begin
                    if (r_tickCnt == c_TICK_FULL) begin
                        w_tickNext = '0;
                        if (r_rxS) begin
                            w_dataNext  = r_shift;
                            w_validNext = 1'b1;
                            w_stateNext = c_IDLE;
                        end else begin
                            w_errorNext = 1'b1;
                            w_stateNext = c_BREAK;
                        end
                    end else begin
                        w_tickNext = r_tickCnt + c_TICK_W'(1);
                    end
                end

                // A held-low line must return high before another start is armed
                c_BREAK: begin
                    if (r_rxS) begin
                        w_stateNext = c_IDLE;
                    end
                end

                default: begin
                    w_stateNext = c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_tickCnt    <= '0;
            r_bitCnt     <= '0;
            r_shift      <= '0;
            r_dataOut    <= '0;
            r_dataValid  <= 1'b0;
            r_frameError <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_tickCnt    <= w_tickNext;
            r_bitCnt     <= w_bitNext;
            r_shift      <= w_shiftNext;
            r_dataOut    <= w_dataNext;
            r_dataValid  <= w_validNext;
            r_frameError <= w_errorNext;
        end
    end

    assign dataOut    = r_dataOut;
    assign dataValid  = r_dataValid;
    assign frameError = r_frameError;
    assign busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Directed frames against a frame-level expectation model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_receiver;

    localparam int c_NEVER = 1 << 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxTick = 1'b0;
    logic       rx = 1'b1;
    logic       rx6 = 1'b1;
    logic [7:0] dataOut;
    logic       dataValid, frameError, busy;
    logic [6:0] dataOut6;
    logic       dataValid6, frameError6, busy6;

    uart_receiver dut (
        .clk(clk), .reset(reset), .rxTick(rxTick), .rx(rx),
        .dataOut(dataOut), .dataValid(dataValid), .frameError(frameError), .busy(busy)
    );

    uart_receiver #(.DATA_BITS(7), .OVERSAMPLE(4)) dut6 (
        .clk(clk), .reset(reset), .rxTick(1'b1), .rx(rx6),
        .dataOut(dataOut6), .dataValid(dataValid6), .frameError(frameError6), .busy(busy6)
    );

    always #5 clk = ~clk;

    typedef struct { int tick; logic err; logic [7:0] data; } ev_t;
    typedef struct { int lo; int hi; } span_t;
    ev_t   evQ[$];
    span_t busyQ[$];
    int    validTicks[$];

    int         tickNum = 0;
    logic       lastTick = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         validCount = 0;
    int         errCount = 0;
    logic [7:0] modelData = 8'h00;
    logic       running = 1'b0;

    // One tick every third clock so the enable path is genuinely exercised
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 3;
            rxTick = (div == 0);
        end
    end

    always @(posedge clk) begin
        lastTick <= rxTick;
        if (rxTick) tickNum <= tickNum + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t tick=%0d)", name, act, exp, $time, tickNum);
        end
    endtask

    // Per-cycle comparison against the frame-level expectations
    initial begin
        logic expV, expE, expB;
        forever begin
            @(negedge clk);
            if (running && !reset) begin
                expV = 1'b0;
                expE = 1'b0;
                if (evQ.size() > 0 && lastTick && tickNum == evQ[0].tick) begin
                    if (evQ[0].err) expE = 1'b1;
                    else begin
                        expV = 1'b1;
                        modelData = evQ[0].data;
                    end
                    void'(evQ.pop_front());
                end
                expB = 1'b0;
                foreach (busyQ[i])
                    if (tickNum >= busyQ[i].lo && tickNum < busyQ[i].hi) expB = 1'b1;
                check("dataValid", dataValid, expV);
                check("frameError", frameError, expE);
                check("dataOut", dataOut, modelData);
                check("busy", busy, expB);
                if (dataValid) begin
                    validCount++;
                    validTicks.push_back(tickNum);
                end
                if (frameError) errCount++;
            end
        end
    end

    task automatic waitTicks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!rxTick) @(posedge clk);
        end
        #1;
    endtask

    // Caller is aligned just after a tick edge; the next tick is the detection tick
    task automatic sendFrame(input logic [7:0] d, input logic stopBit, output int det);
        det = tickNum + 1;
        if (stopBit) begin
            evQ.push_back('{det + 152, 1'b0, d});
            busyQ.push_back('{det, det + 152});
        end else begin
            evQ.push_back('{det + 152, 1'b1, 8'h00});
            busyQ.push_back('{det, c_NEVER});
        end
        rx = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            waitTicks(16);
        end
        rx = stopBit;
        waitTicks(16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, d3, d4, vc, ec, n, lat;
        logic       seen, err6;
        logic [6:0] b6;

        repeat (3) @(posedge clk);
        #1;
        check("rst dataOut", dataOut, 8'h00);
        check("rst dataValid", dataValid, 1'b0);
        check("rst frameError", frameError, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst busy6", busy6, 1'b0);
        reset = 1'b0;
        running = 1'b1;
        waitTicks(4);

        // 1: single frame
        vc = validCount;
        sendFrame(8'h55, 1'b1, d1);
        check("t1 count", validCount - vc, 1);
        check("t1 latency", validTicks[validTicks.size() - 1] - d1, 152);
        check("t1 data", dataOut, 8'h55);
        check("t1 noerr", errCount, 0);

        // 2: back-to-back
        vc = validCount;
        sendFrame(8'hA3, 1'b1, d1);
        sendFrame(8'h0F, 1'b1, d2);
        waitTicks(4);
        n = validTicks.size();
        check("t2 count", validCount - vc, 2);
        check("t2 spacing", validTicks[n - 1] - validTicks[n - 2], 160);
        check("t2 data", dataOut, 8'h0F);

        // 3: glitch rejection
        vc = validCount;
        d3 = tickNum + 1;
        busyQ.push_back('{d3, d3 + 8});
        rx = 1'b0;
        waitTicks(4);
        rx = 1'b1;
        waitTicks(6);
        check("t3 busy", busy, 1'b0);
        check("t3 nostrobe", validCount - vc, 0);
        sendFrame(8'h3C, 1'b1, d3);
        check("t3 data", dataOut, 8'h3C);

        // 4: frame error then break
        ec = errCount;
        sendFrame(8'h81, 1'b0, d4);
        waitTicks(20);
        check("t4 hold data", dataOut, 8'h3C);
        check("t4 busy in break", busy, 1'b1);
        waitTicks(20);
        rx = 1'b1;
        busyQ[busyQ.size() - 1].hi = tickNum + 1;
        waitTicks(4);
        check("t4 err count", errCount - ec, 1);
        check("t4 idle", busy, 1'b0);
        sendFrame(8'hF0, 1'b1, d4);
        check("t4 data", dataOut, 8'hF0);

        // 5: reset after the third data bit
        vc = validCount;
        d1 = tickNum + 1;
        busyQ.push_back('{d1, c_NEVER});
        b6 = 7'h46;
        rx = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 3; i++) begin
            rx = b6[i];
            waitTicks(16);
        end
        rx = 1'b1;
        reset = 1'b1;
        modelData = 8'h00;
        busyQ.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5 dataOut", dataOut, 8'h00);
        check("t5 dataValid", dataValid, 1'b0);
        check("t5 frameError", frameError, 1'b0);
        check("t5 busy", busy, 1'b0);
        waitTicks(8);
        check("t5 nostrobe", validCount - vc, 0);
        sendFrame(8'h5A, 1'b1, d1);
        check("t5 data", dataOut, 8'h5A);

        // 6: tick tied high, 7 data bits, 4x oversample
        b6 = 7'h2B;
        seen = 1'b0;
        err6 = 1'b0;
        lat = 0;
        @(posedge clk);
        #1;
        fork
            begin
                rx6 = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                for (int i = 0; i < 7; i++) begin
                    rx6 = b6[i];
                    repeat (4) @(posedge clk);
                    #1;
                end
                rx6 = 1'b1;
                repeat (4) @(posedge clk);
                #1;
            end
            begin
                for (int k = 1; k <= 60 && !seen; k++) begin
                    @(posedge clk);
                    #1;
                    if (frameError6) err6 = 1'b1;
                    if (dataValid6) begin
                        seen = 1'b1;
                        lat = k;
                    end
                end
            end
        join
        check("t6 seen", seen, 1'b1);
        check("t6 latency", lat, 37);
        check("t6 data", dataOut6, 7'h2B);
        check("t6 noerr", err6, 1'b0);
        @(posedge clk);
        #1;
        check("t6 pulse width", dataValid6, 1'b0);
        check("t6 idle", busy6, 1'b0);

        waitTicks(4);
        check("final queue empty", evQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
